// File: rtl/fp_issue_stage.sv
// fp_issue_stage
// ---------------------------------------------------------------------------
// Issue/hold stage that sits directly in front of the FP_Unit datapath.
// A single FP request is taken from decode over a valid/ready handshake.
// Its operands and controls are registered and held steady on the FP_Unit
// inputs for a per-op number of cycles. The FP_Unit result is then captured
// and offered to writeback over a second valid/ready handshake.
//
// Ports
//   in_clk, in_rst             clock, synchronous active-high reset
//   in_req_valid/out_req_ready request handshake from decode
//   in_rs1, in_rs2, in_FPU_Op, in_fmt, in_output_fmt, in_addsub_ctrl,
//   in_ctrl_minmax_sgnj_cmp, in_rd          request fields
//   out_fpu_*                  held operands/controls driven into FP_Unit
//   in_fpu_result              FP_Unit out_data
//   out_rsp_valid/in_rsp_ready response handshake to writeback
//   out_rsp_data, out_rsp_rd, out_rsp_illegal  response payload
//
// Build option
//   FP_ISSUE_BYPASS_EN : when defined, a new request can be accepted in the
//                        same cycle the pending response is consumed. This
//                        removes the IDLE bubble between back-to-back ops.
// ---------------------------------------------------------------------------
module fp_issue_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int LAT_ADDSUB = 2,
    parameter int LAT_MUL    = 3,
    parameter int LAT_DIV    = 8,
    parameter int LAT_MISC   = 1
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic                  in_req_valid,
    output logic                  out_req_ready,
    input  logic [DATA_WIDTH-1:0] in_rs1,
    input  logic [DATA_WIDTH-1:0] in_rs2,
    input  logic [3:0]            in_FPU_Op,
    input  logic                  in_fmt,
    input  logic                  in_output_fmt,
    input  logic                  in_addsub_ctrl,
    input  logic [2:0]            in_ctrl_minmax_sgnj_cmp,
    input  logic [4:0]            in_rd,
    output logic [DATA_WIDTH-1:0] out_fpu_rs1,
    output logic [DATA_WIDTH-1:0] out_fpu_rs2,
    output logic [3:0]            out_fpu_op,
    output logic                  out_fpu_fmt,
    output logic                  out_fpu_output_fmt,
    output logic                  out_fpu_addsub_ctrl,
    output logic [2:0]            out_fpu_ctrl,
    input  logic [DATA_WIDTH-1:0] in_fpu_result,
    output logic                  out_rsp_valid,
    input  logic                  in_rsp_ready,
    output logic [DATA_WIDTH-1:0] out_rsp_data,
    output logic [4:0]            out_rsp_rd,
    output logic                  out_rsp_illegal
);

    // Latencies outside 1..255 cannot be represented by the 8-bit
    // countdown, so they are rejected at elaboration.
    generate
        if (LAT_ADDSUB < 1 || LAT_ADDSUB > 255 ||
            LAT_MUL    < 1 || LAT_MUL    > 255 ||
            LAT_DIV    < 1 || LAT_DIV    > 255 ||
            LAT_MISC   < 1 || LAT_MISC   > 255) begin : g_bad_latency
            $error("fp_issue_stage: every LAT_* parameter must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] LAT8_ADDSUB = 8'(LAT_ADDSUB);
    localparam logic [7:0] LAT8_MUL    = 8'(LAT_MUL);
    localparam logic [7:0] LAT8_DIV    = 8'(LAT_DIV);
    localparam logic [7:0] LAT8_MISC   = 8'(LAT_MISC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] cnt;
    logic [7:0] lat_sel;
    logic       ready_state;
    logic       accept;
    logic       req_illegal;

    // Any op with the top bit set has no FP_Unit meaning and skips EXEC.
    assign req_illegal = in_FPU_Op[3];

    // Hold-cycle count for the op being accepted. Ops 0011..0111 share the
    // misc latency.
    always_comb begin
        lat_sel = LAT8_MISC;
        case (in_FPU_Op)
            4'b0000: lat_sel = LAT8_ADDSUB;
            4'b0001: lat_sel = LAT8_MUL;
            4'b0010: lat_sel = LAT8_DIV;
            default: lat_sel = LAT8_MISC;
        endcase
    end

    // Ready is forced low while reset is asserted, so that no request can be
    // taken in a cycle whose state is about to be discarded.
    always_comb begin
`ifdef FP_ISSUE_BYPASS_EN
        ready_state = (state == IDLE) || ((state == DONE) && in_rsp_ready);
`else
        ready_state = (state == IDLE);
`endif
    end

    assign out_req_ready = ready_state & ~in_rst;
    assign accept        = in_req_valid & out_req_ready;
    assign out_rsp_valid = (state == DONE);

    // State register.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. In DONE, an accept is only possible when the bypass
    // build is enabled; it overrides the plain return to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = req_illegal ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (cnt == 8'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (in_rsp_ready) begin
                    state_next = IDLE;
                end
                if (accept) begin
                    state_next = req_illegal ? DONE : EXEC;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath registers. The FP_Unit-facing copies change only on an
    // accept, so they stay frozen through EXEC and keep the last issued
    // values afterwards. The result is sampled in the final EXEC cycle.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            cnt                 <= 8'd0;
            out_fpu_rs1         <= '0;
            out_fpu_rs2         <= '0;
            out_fpu_op          <= 4'd0;
            out_fpu_fmt         <= 1'b0;
            out_fpu_output_fmt  <= 1'b0;
            out_fpu_addsub_ctrl <= 1'b0;
            out_fpu_ctrl        <= 3'd0;
            out_rsp_data        <= '0;
            out_rsp_rd          <= 5'd0;
            out_rsp_illegal     <= 1'b0;
        end else if (accept) begin
            out_fpu_rs1         <= in_rs1;
            out_fpu_rs2         <= in_rs2;
            out_fpu_op          <= in_FPU_Op;
            out_fpu_fmt         <= in_fmt;
            out_fpu_output_fmt  <= in_output_fmt;
            out_fpu_addsub_ctrl <= in_addsub_ctrl;
            out_fpu_ctrl        <= in_ctrl_minmax_sgnj_cmp;
            out_rsp_rd          <= in_rd;
            if (req_illegal) begin
                cnt             <= 8'd0;
                out_rsp_data    <= '0;
                out_rsp_illegal <= 1'b1;
            end else begin
                cnt <= lat_sel;
            end
        end else if (state == EXEC) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
                out_rsp_data    <= in_fpu_result;
                out_rsp_illegal <= 1'b0;
            end
        end
    end

endmodule
